mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the CPU's IMEM and DMEM request interfaces.
//  Serves both ports from one shared word array, with a fixed latency per port.
//  Each accepted request gets exactly one single-cycle *_resp pulse.
//  Sits in the testbench/SoC top, directly opposite the cpu IMEM/DMEM ports.
// PARAMETERS
//  MEM_WORDS     4096          array depth in 32-bit words (power of 2)
//  BASE_ADDR     32'h1ECE_B000 byte address that maps to word 0
//  IMEM_LATENCY  2             cycles from acceptance to imem_resp (>=1)
//  DMEM_LATENCY  3             cycles from acceptance to dmem_resp (>=1)
// PORTS
//  clk         in   1   clock; all logic on posedge
//  rst_n       in   1   synchronous active-low reset
//  imem_addr   in   32  fetch byte address
//  imem_rmask  in   4   fetch read mask; nonzero = request
//  imem_rdata  out  32  fetch word; valid only while imem_resp=1
//  imem_resp   out  1   one-cycle fetch completion pulse
//  dmem_addr   in   32  data byte address
//  dmem_rmask  in   4   load byte mask
//  dmem_wmask  in   4   store byte-lane mask
//  dmem_wdata  in   32  store data, already lane-aligned by the CPU
//  dmem_rdata  out  32  full aligned word; valid only while dmem_resp=1
//  dmem_resp   out  1   one-cycle data completion pulse
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): both FSMs go to IDLE; *_resp=0, *_rdata=0.
//    The array is not cleared. Reset aborts any in-flight request, and a
//    pending store is dropped.
//  - Per-port FSM states: IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: when the mask is nonzero (rmask|wmask), capture addr, masks and
//          wdata, load cnt=LATENCY-1, then go to WAIT (or straight to RESP
//          if LATENCY=1).
//    WAIT: decrement cnt; at cnt=0, go to RESP.
//    RESP: assert *_resp=1 for this cycle only; rdata = array[idx]; then
//          return to IDLE.
//  - Requests present during WAIT/RESP are ignored. The CPU holds its request
//    stable while frozen, so the responder samples the next request in the
//    first IDLE cycle after RESP. Back-to-back throughput is 1 per LATENCY+1
//    cycles.
//  - Captured fields are authoritative. Input changes after acceptance have no
//    effect.
//  - Index: idx = ((addr - BASE_ADDR) >> 2) mod MEM_WORDS. addr[1:0] is
//    ignored. Out-of-range addresses wrap; no error is raised.
//  - Store: in the dmem RESP cycle, write bytes where wmask[i]=1 with
//    wdata[8i+7:8i].
//  - dmem rmask and wmask both nonzero: the write is performed, and rdata
//    returns the pre-write word.
//  - Same-cycle imem RESP and dmem store RESP to the same idx: imem returns
//    the old word (read-before-write).
//  - *_rdata is 0 whenever *_resp=0. The imem port never writes.
// CONFIGURATION
//  MEM_RESPONDER_RANDOM_LAT_EN
//  - Defined: each port has a 16-bit Fibonacci LFSR (taps 16,14,13,11;
//    seed 16'hACE1 on reset). Effective latency = LATENCY + lfsr[1:0]
//    (range +0..+3), sampled at acceptance. The LFSR steps every cycle.
//  - Undefined: latency is exactly LATENCY and no LFSR logic is built.
// STRUCTURE
//  - mem_responder_pkg: enum mem_state_t {IDLE, WAIT, RESP};
//    MEM_CNT_W=8; function word_idx().
//  - Sub-module mem_port_fsm: a single-port latency FSM plus captured request
//    registers. It is instantiated twice (imem, dmem) around a shared array
//    with byte-enable writes.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles while imem_rmask=4'hF
//     -> imem_resp=0 and imem_rdata=0 throughout; first resp exactly
//     IMEM_LATENCY+1 cycles after release.
//  2. Store then load: store at 0x1ECEB010 with wmask=4'b0110,
//     wdata=32'hAABBCCDD over word 32'h11223344
//     -> a later load returns 32'h11BBCC44; dmem_resp comes DMEM_LATENCY
//     cycles after acceptance.
//  3. Input change: change dmem_addr and wdata one cycle after acceptance
//     -> the write goes to the originally captured address with the original
//     data; exactly one dmem_resp.
//  4. Same-cycle conflict: imem and dmem RESP in the same cycle to word 5,
//     with a store of 32'hFFFFFFFF over 0
//     -> imem_rdata=0; a subsequent read returns 32'hFFFFFFFF.
//  5. Wrap: load at BASE_ADDR + 4*MEM_WORDS
//     -> returns word 0; no X on outputs.
//  6. Mid-request reset: pull rst_n low during dmem WAIT of a store
//     -> no dmem_resp, array unchanged, FSM IDLE after release.
//     Random-latency build: every resp falls within LATENCY..LATENCY+3.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder.
// The optional random-latency build is selected with MEM_RESPONDER_RANDOM_LAT_EN;
// the LFSR helpers below are only referenced when that macro is defined.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int MEM_CNT_W = 8;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Byte address to word index: offset from the base, drop the byte lane
    // bits, then wrap into the array depth (depth is a power of two).
    function automatic logic [31:0] word_idx(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned words
    );
        logic [31:0] offset;
        offset = addr - base;
        return (offset >> 2) & (words - 1);
    endfunction

    // One step of the 16-bit Fibonacci LFSR with taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    endfunction

endpackage

// File: rtl/mem_responder_port_fsm.sv
// Single-port latency FSM with captured request registers.
// With MEM_RESPONDER_RANDOM_LAT_EN defined, a per-port LFSR adds 0..3 cycles
// of latency sampled at acceptance; otherwise latency is exactly LATENCY.
module mem_port_fsm
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h1ECE_B000,
    localparam int         IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr_i,
    input  logic [3:0]       rmask_i,
    input  logic [3:0]       wmask_i,
    input  logic [31:0]      wdata_i,
    output logic             resp_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [3:0]       wmask_o,
    output logic [31:0]      wdata_o
);

    mem_state_t           state_q, state_d;
    logic [MEM_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           wmask_q, wmask_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [MEM_CNT_W-1:0] load_cnt;
    logic                 req;

`ifdef MEM_RESPONDER_RANDOM_LAT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // LFSR free-runs every cycle; its low bits stretch the latency at acceptance.
    always_comb begin
        lfsr_d   = lfsr_next(lfsr_q);
        load_cnt = MEM_CNT_W'(LATENCY - 1) + MEM_CNT_W'(lfsr_q[1:0]);
    end

    // LFSR register, reseeded on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Fixed latency: the countdown always starts at LATENCY-1.
    always_comb begin
        load_cnt = MEM_CNT_W'(LATENCY - 1);
    end
`endif

    assign req = (|rmask_i) | (|wmask_i);

    // State register and captured request fields; reset aborts any request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state: capture in IDLE, count down in WAIT, one RESP cycle, back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = IDX_W'(word_idx(addr_i, BASE_ADDR, MEM_WORDS));
                    wmask_d = wmask_i;
                    wdata_d = wdata_i;
                    cnt_d   = load_cnt;
                    state_d = (load_cnt == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - MEM_CNT_W'(1);
                if (cnt_q == MEM_CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: the response pulse is exactly the RESP state; fields are the captured ones.
    always_comb begin
        resp_o  = (state_q == RESP);
        idx_o   = idx_q;
        wmask_o = wmask_q;
        wdata_o = wdata_q;
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder serving the CPU IMEM and DMEM ports from one shared
// word array. Optional random latency: define MEM_RESPONDER_RANDOM_LAT_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h1ECE_B000,
    parameter int unsigned IMEM_LATENCY = 2,
    parameter int unsigned DMEM_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [31:0] mem_array [MEM_WORDS];

    logic [IDX_W-1:0] imem_idx, dmem_idx;
    logic [3:0]       imem_wmask_cap, dmem_wmask_cap;
    logic [31:0]      imem_wdata_cap, dmem_wdata_cap;

    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_data;

    mem_port_fsm #(
        .LATENCY   (IMEM_LATENCY),
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) u_imem_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_i  (imem_addr),
        .rmask_i (imem_rmask),
        .wmask_i (4'b0000),
        .wdata_i (32'h0000_0000),
        .resp_o  (imem_resp),
        .idx_o   (imem_idx),
        .wmask_o (imem_wmask_cap),
        .wdata_o (imem_wdata_cap)
    );

    mem_port_fsm #(
        .LATENCY   (DMEM_LATENCY),
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) u_dmem_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_i  (dmem_addr),
        .rmask_i (dmem_rmask),
        .wmask_i (dmem_wmask),
        .wdata_i (dmem_wdata),
        .resp_o  (dmem_resp),
        .idx_o   (dmem_idx),
        .wmask_o (dmem_wmask_cap),
        .wdata_o (dmem_wdata_cap)
    );

    // Read data is the current array word during RESP and zero otherwise; since
    // stores commit at the end of RESP, same-cycle readers see the old word.
    always_comb begin
        imem_rdata = imem_resp ? mem_array[imem_idx] : 32'h0000_0000;
        dmem_rdata = dmem_resp ? mem_array[dmem_idx] : 32'h0000_0000;
    end

    // Write port select: dmem owns it; the imem write lanes are tied off at the
    // instance, so the imem branch always presents an all-zero byte mask.
    always_comb begin
        wr_idx  = '0;
        wr_mask = 4'b0000;
        wr_data = 32'h0000_0000;
        if (dmem_resp) begin
            wr_idx  = dmem_idx;
            wr_mask = dmem_wmask_cap;
            wr_data = dmem_wdata_cap;
        end else if (imem_resp) begin
            wr_idx  = imem_idx;
            wr_mask = imem_wmask_cap;
            wr_data = imem_wdata_cap;
        end
    end

    // Byte-enable store at the end of the RESP cycle; a reset at that edge drops it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem_array[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a word-array model.
module tb_mem_responder;

    localparam int unsigned MEM_WORDS    = 4096;
    localparam logic [31:0] BASE         = 32'h1ECE_B000;
    localparam int          IMEM_LAT     = 2;
    localparam int          DMEM_LAT     = 3;
`ifdef MEM_RESPONDER_RANDOM_LAT_EN
    localparam int          EXTRA        = 3;
`else
    localparam int          EXTRA        = 0;
`endif
    localparam int          SLACK        = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] model [int];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    logic [31:0] d_rdata, i_rdata;
    int          d_lat, i_lat;
    bit          d_got, i_got;
    time         d_time, i_time;

    mem_responder #(
        .MEM_WORDS    (MEM_WORDS),
        .BASE_ADDR    (BASE),
        .IMEM_LATENCY (IMEM_LAT),
        .DMEM_LATENCY (DMEM_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Equality comparison against a bench-computed value.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Range comparison for response latency; -1 means the response never came.
    task automatic checkLatency(input string name, input int lat, input int lo, input int hi);
        tests_run++;
        if (lat < lo || lat > hi) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d cycles, expected %0d..%0d", name, lat, lo, hi);
        end
    endtask

    // Reference model: word index from the address rule, byte-lane merge for stores.
    function automatic int modelIdx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'((off / 4) % MEM_WORDS);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        int idx;
        idx = modelIdx(addr);
        return model.exists(idx) ? model[idx] : 32'h0;
    endfunction

    function automatic void modelStore(input logic [31:0] addr, input logic [3:0] wmask, input logic [31:0] wdata);
        logic [31:0] w;
        int idx;
        idx = modelIdx(addr);
        w = model.exists(idx) ? model[idx] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) w[8*i +: 8] = wdata[8*i +: 8];
        end
        model[idx] = w;
    endfunction

    // One DMEM transaction, started at a negedge with the port idle; returns
    // one cycle after the pulse so the next request lands in an IDLE cycle.
    task automatic dmemXfer(input logic [31:0] addr, input logic [3:0] rmask, input logic [3:0] wmask,
                            input logic [31:0] wdata, output logic [31:0] rdata, output int lat,
                            output bit got, output time t);
        int bad_idle;
        bad_idle = 0;
        got = 0;
        lat = -1;
        rdata = 32'h0;
        t = 0;
        dmem_addr = addr;
        dmem_rmask = rmask;
        dmem_wmask = wmask;
        dmem_wdata = wdata;
        for (int k = 1; k <= DMEM_LAT + EXTRA + SLACK && !got; k++) begin
            @(negedge clk);
            if (dmem_resp) begin
                got = 1;
                lat = k;
                rdata = dmem_rdata;
                t = $time;
            end else if (dmem_rdata !== 32'h0) begin
                bad_idle++;
            end
        end
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        if (got) begin
            @(negedge clk);
            checkOutput("dmem_resp_single_cycle", {31'b0, dmem_resp}, 32'h0);
        end
        checkOutput("dmem_rdata_zero_when_idle", bad_idle, 32'h0);
        checkLatency("dmem_latency", lat, DMEM_LAT, DMEM_LAT + EXTRA);
    endtask

    // One IMEM fetch, same protocol as dmemXfer.
    task automatic imemXfer(input logic [31:0] addr, output logic [31:0] rdata, output int lat,
                            output bit got, output time t);
        int bad_idle;
        bad_idle = 0;
        got = 0;
        lat = -1;
        rdata = 32'h0;
        t = 0;
        imem_addr = addr;
        imem_rmask = 4'hF;
        for (int k = 1; k <= IMEM_LAT + EXTRA + SLACK && !got; k++) begin
            @(negedge clk);
            if (imem_resp) begin
                got = 1;
                lat = k;
                rdata = imem_rdata;
                t = $time;
            end else if (imem_rdata !== 32'h0) begin
                bad_idle++;
            end
        end
        imem_rmask = 4'h0;
        if (got) begin
            @(negedge clk);
            checkOutput("imem_resp_single_cycle", {31'b0, imem_resp}, 32'h0);
        end
        checkOutput("imem_rdata_zero_when_idle", bad_idle, 32'h0);
        checkLatency("imem_latency", lat, IMEM_LAT, IMEM_LAT + EXTRA);
    endtask

    // Apply one table vector on DMEM and compare its read data if it has one.
    task automatic applyStimulus(input int n, input vec_t v);
        logic [31:0] rd;
        int  lat;
        bit  got;
        time t;
        dmemXfer(v.addr, v.rmask, v.wmask, v.wdata, rd, lat, got, t);
        if (v.wmask != 4'h0) modelStore(v.addr, v.wmask, v.wdata);
        if (v.chk) checkOutput($sformatf("vec%0d_rdata", n), rd, v.exp);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int resp_count;
        int k_seen;
        logic [31:0] exp;
        logic [31:0] a;
        logic [3:0]  rm, wm;
        logic [31:0] wd;
        int op, idx;

        vecs[0] = '{32'h1ECE_B010, 4'h0, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
        vecs[1] = '{32'h1ECE_B010, 4'h0, 4'h6, 32'hAABB_CCDD, 1'b0, 32'h0};
        vecs[2] = '{32'h1ECE_B010, 4'hF, 4'h0, 32'h0,         1'b1, 32'h11BB_CC44};
        vecs[3] = '{32'h1ECE_B000, 4'h0, 4'hF, 32'hCAFE_0001, 1'b0, 32'h0};
        vecs[4] = '{32'h1ECE_F000, 4'hF, 4'h0, 32'h0,         1'b1, 32'hCAFE_0001};
        vecs[5] = '{32'h1ECE_B013, 4'h1, 4'h0, 32'h0,         1'b1, 32'h11BB_CC44};
        vecs[6] = '{32'h1ECE_B010, 4'hF, 4'h8, 32'h9900_0000, 1'b1, 32'h11BB_CC44};
        vecs[7] = '{32'h1ECE_B010, 4'hF, 4'h0, 32'h0,         1'b1, 32'h99BB_CC44};
        vecs[8] = '{32'h1ECE_AFFC, 4'h0, 4'hF, 32'h1234_5678, 1'b0, 32'h0};
        vecs[9] = '{32'h1ECE_EFFC, 4'hF, 4'h0, 32'h0,         1'b1, 32'h1234_5678};

        rst_n = 1'b0;
        imem_addr = BASE;
        imem_rmask = 4'hF;
        dmem_addr = 32'h0;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'h0;

        // Reset held for three edges with a fetch pending: no pulse, zero data.
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_imem_resp", {31'b0, imem_resp}, 32'h0);
            checkOutput("reset_imem_rdata", imem_rdata, 32'h0);
            checkOutput("reset_dmem_resp", {31'b0, dmem_resp}, 32'h0);
        end
        // Released here: this cycle accepts, so the pulse lands IMEM_LAT cycles
        // on, which is IMEM_LAT+1 cycles after the last reset cycle.
        rst_n = 1'b1;
        k_seen = -1;
        for (int k = 1; k <= IMEM_LAT + EXTRA + SLACK && k_seen < 0; k++) begin
            @(negedge clk);
            if (imem_resp) k_seen = k;
        end
        imem_rmask = 4'h0;
        @(negedge clk);
        checkLatency("reset_release_first_resp", k_seen, IMEM_LAT, IMEM_LAT + EXTRA);

        // Directed vector table: store/merge, wrap, ignored lane bits, read+write.
        for (int n = 0; n < 10; n++) begin
            applyStimulus(n, vecs[n]);
        end

        // Wrapped fetch on the imem port.
        imemXfer(BASE + 32'h0000_8000, i_rdata, i_lat, i_got, i_time);
        checkOutput("imem_wrap_rdata", i_rdata, 32'hCAFE_0001);

        // Input change after acceptance: captured address and data win.
        dmemXfer(BASE + 32'h50, 4'h0, 4'hF, 32'h5555_5555, d_rdata, d_lat, d_got, d_time);
        dmemXfer(BASE + 32'h54, 4'h0, 4'hF, 32'h6666_6666, d_rdata, d_lat, d_got, d_time);
        dmem_addr = BASE + 32'h50;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'hA5A5_A5A5;
        resp_count = 0;
        for (int k = 1; k <= DMEM_LAT + EXTRA + SLACK; k++) begin
            @(negedge clk);
            if (k == 1) begin
                dmem_addr = BASE + 32'h54;
                dmem_wdata = 32'h5A5A_5A5A;
            end
            if (dmem_resp) begin
                resp_count++;
                dmem_wmask = 4'h0;
            end
        end
        dmem_wmask = 4'h0;
        checkOutput("inchg_resp_count", resp_count, 32'd1);
        dmemXfer(BASE + 32'h50, 4'hF, 4'h0, 32'h0, d_rdata, d_lat, d_got, d_time);
        checkOutput("inchg_orig_addr", d_rdata, 32'hA5A5_A5A5);
        dmemXfer(BASE + 32'h54, 4'hF, 4'h0, 32'h0, d_rdata, d_lat, d_got, d_time);
        checkOutput("inchg_other_addr", d_rdata, 32'h6666_6666);

        // Same-cycle conflict on word 5: dmem starts one cycle ahead of imem so
        // both reach their response together.
        dmemXfer(BASE + 32'h14, 4'h0, 4'hF, 32'h0, d_rdata, d_lat, d_got, d_time);
        fork
            begin
                dmemXfer(BASE + 32'h14, 4'h0, 4'hF, 32'hFFFF_FFFF, d_rdata, d_lat, d_got, d_time);
            end
            begin
                @(negedge clk);
                imemXfer(BASE + 32'h14, i_rdata, i_lat, i_got, i_time);
            end
        join
`ifndef MEM_RESPONDER_RANDOM_LAT_EN
        checkOutput("conflict_same_cycle", {31'b0, (d_got && i_got && d_time == i_time)}, 32'd1);
        checkOutput("conflict_imem_old_word", i_rdata, 32'h0);
`endif
        dmemXfer(BASE + 32'h14, 4'hF, 4'h0, 32'h0, d_rdata, d_lat, d_got, d_time);
        checkOutput("conflict_after_store", d_rdata, 32'hFFFF_FFFF);

        // Reset during the WAIT of a store: no pulse, word unchanged.
        dmemXfer(BASE + 32'h1C, 4'h0, 4'hF, 32'h0BAD_F00D, d_rdata, d_lat, d_got, d_time);
        dmem_addr = BASE + 32'h1C;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'hFFFF_0000;
        resp_count = 0;
        @(negedge clk);
        if (dmem_resp) resp_count++;
        rst_n = 1'b0;
        dmem_wmask = 4'h0;
        repeat (2) begin
            @(negedge clk);
            if (dmem_resp) resp_count++;
        end
        rst_n = 1'b1;
        repeat (DMEM_LAT + EXTRA + SLACK) begin
            @(negedge clk);
            if (dmem_resp) resp_count++;
        end
        checkOutput("midrst_no_resp", resp_count, 32'd0);
        dmemXfer(BASE + 32'h1C, 4'hF, 4'h0, 32'h0, d_rdata, d_lat, d_got, d_time);
        checkOutput("midrst_word_unchanged", d_rdata, 32'h0BAD_F00D);

        // Randomized traffic over words 0..15, with wrapped aliases and junk lane bits.
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            dmemXfer(BASE + 32'(4 * w), 4'h0, 4'hF, wd, d_rdata, d_lat, d_got, d_time);
            modelStore(BASE + 32'(4 * w), 4'hF, wd);
        end
        for (int n = 0; n < 150; n++) begin
            op  = int'($urandom_range(0, 3));
            idx = int'($urandom_range(0, 15));
            a   = BASE + 32'(4 * idx) + 32'(4 * MEM_WORDS * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            wd  = $urandom;
            wm  = 4'($urandom_range(1, 15));
            rm  = 4'($urandom_range(1, 15));
            exp = modelRead(a);
            case (op)
                0: begin
                    dmemXfer(a, rm, 4'h0, 32'h0, d_rdata, d_lat, d_got, d_time);
                    checkOutput($sformatf("rand%0d_load", n), d_rdata, exp);
                end
                1: begin
                    dmemXfer(a, 4'h0, wm, wd, d_rdata, d_lat, d_got, d_time);
                    modelStore(a, wm, wd);
                end
                2: begin
                    dmemXfer(a, rm, wm, wd, d_rdata, d_lat, d_got, d_time);
                    checkOutput($sformatf("rand%0d_rmw_old", n), d_rdata, exp);
                    modelStore(a, wm, wd);
                end
                default: begin
                    imemXfer(a, i_rdata, i_lat, i_got, i_time);
                    checkOutput($sformatf("rand%0d_fetch", n), i_rdata, exp);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
